// File: rtl/easyaxi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_pkg
// Description : Shared encodings for the outstanding-slot scheduler: per-slot
//               lifecycle state and scheduler FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package easyaxi_pkg;

    // Slot lifecycle: allocated -> backend done -> drained by the scheduler
    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_BUSY  = 2'd1,
        SLOT_READY = 2'd2
    } slot_state_e;

    // Scheduler: pick a slot in IDLE, stream its beats in ISSUE
    typedef enum logic [0:0] {
        SCH_IDLE  = 1'b0,
        SCH_ISSUE = 1'b1
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/easyaxi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_rr_arb
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one above the last granted index, wrapping,
//               and reports the first requester found.
// Revision    : 1.0 - initial release
// ============================================================================
module easyaxi_rr_arb #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_ptr,
    output logic [$clog2(N)-1:0] grant_ptr,
    output logic                 grant_any
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest requester above
    // last_ptr is the final assignment; offset N wraps onto last_ptr itself
    always_comb begin
        grant_ptr = '0;
        grant_any = 1'b0;
        w_idx     = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = last_ptr + PTR_W'(k);
            if (req[w_idx]) begin
                grant_ptr = w_idx;
                grant_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/easyaxi_ost_sched.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_ost_sched
// Description : Outstanding-transaction slot table with a round-robin
//               response scheduler. Slots are allocated lowest-free-first,
//               marked ready by the backend, and drained one burst at a time
//               when also at the head of their ID ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module easyaxi_ost_sched
    import easyaxi_pkg::*;
#(
    parameter int OST_DEPTH = 16,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [ID_WIDTH-1:0]          alloc_id,
    input  logic [LEN_WIDTH-1:0]         alloc_len,
    output logic [$clog2(OST_DEPTH)-1:0] alloc_ptr,
    input  logic                         done_valid,
    input  logic [$clog2(OST_DEPTH)-1:0] done_ptr,
    input  logic [OST_DEPTH-1:0]         order_bits,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(OST_DEPTH)-1:0] resp_ptr,
    output logic [ID_WIDTH-1:0]          resp_id,
    output logic                         resp_last
);

    localparam int PTR_W = $clog2(OST_DEPTH);

    slot_state_e          r_slot_st  [OST_DEPTH];
    logic [ID_WIDTH-1:0]  r_slot_id  [OST_DEPTH];
    logic [LEN_WIDTH-1:0] r_slot_len [OST_DEPTH];

    sched_state_e         r_fsm;
    sched_state_e         w_fsm_nxt;
    logic [PTR_W-1:0]     r_sel;
    logic [PTR_W-1:0]     r_rr;
    logic [LEN_WIDTH-1:0] r_cnt;

    logic [OST_DEPTH-1:0] w_free_vec;
    logic [OST_DEPTH-1:0] w_ready_vec;
    logic [OST_DEPTH-1:0] w_elig;
    logic [PTR_W-1:0]     w_grant_ptr;
    logic                 w_grant_any;
    logic                 w_alloc_fire;
    logic                 w_grant_take;
    logic                 w_beat_fire;
    logic                 w_last_fire;

    for (genvar gi = 0; gi < OST_DEPTH; gi++) begin : g_slot_vec
        assign w_free_vec[gi]  = (r_slot_st[gi] == SLOT_FREE);
        assign w_ready_vec[gi] = (r_slot_st[gi] == SLOT_READY);
    end

    assign w_elig       = w_ready_vec & order_bits;
    assign alloc_ready  = |w_free_vec;
    assign w_alloc_fire = alloc_valid & alloc_ready;

    // Lowest-index free slot, derived from registered state only so a slot
    // released this cycle is not offered until the next one
    always_comb begin
        alloc_ptr = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            if (w_free_vec[i]) begin
                alloc_ptr = PTR_W'(i);
            end
        end
    end

    easyaxi_rr_arb #(
        .N (OST_DEPTH)
    ) u_rr_arb (
        .req       (w_elig),
        .last_ptr  (r_rr),
        .grant_ptr (w_grant_ptr),
        .grant_any (w_grant_any)
    );

    // Slot table: alloc, done and free always target slots in different
    // states, so the three updates never collide on one slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                r_slot_st[i]  <= SLOT_FREE;
                r_slot_id[i]  <= '0;
                r_slot_len[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                if (w_alloc_fire && (alloc_ptr == PTR_W'(i))) begin
                    r_slot_st[i]  <= SLOT_BUSY;
                    r_slot_id[i]  <= alloc_id;
                    r_slot_len[i] <= alloc_len;
                end else if (done_valid && (done_ptr == PTR_W'(i)) &&
                             (r_slot_st[i] == SLOT_BUSY)) begin
                    r_slot_st[i] <= SLOT_READY;
                end else if (w_last_fire && (r_sel == PTR_W'(i))) begin
                    r_slot_st[i] <= SLOT_FREE;
                end
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= SCH_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Scheduler next state and handshake decode
    always_comb begin
        w_fsm_nxt    = r_fsm;
        resp_valid   = 1'b0;
        w_grant_take = 1'b0;
        w_beat_fire  = 1'b0;
        w_last_fire  = 1'b0;
        case (r_fsm)
            SCH_IDLE: begin
                if (w_grant_any) begin
                    w_grant_take = 1'b1;
                    w_fsm_nxt    = SCH_ISSUE;
                end
            end
            SCH_ISSUE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_beat_fire = 1'b1;
                    if (resp_last) begin
                        w_last_fire = 1'b1;
                        w_fsm_nxt   = SCH_IDLE;
                    end
                end
            end
            default: w_fsm_nxt = SCH_IDLE;
        endcase
    end

    // Grant latch, round-robin pointer and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
            r_rr  <= PTR_W'(OST_DEPTH - 1);
            r_cnt <= '0;
        end else if (w_grant_take) begin
            r_sel <= w_grant_ptr;
            r_rr  <= w_grant_ptr;
            r_cnt <= '0;
        end else if (w_beat_fire && !w_last_fire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign resp_ptr  = r_sel;
    assign resp_id   = r_slot_id[r_sel];
    assign resp_last = (r_fsm == SCH_ISSUE) && (r_cnt == r_slot_len[r_sel]);

endmodule
`default_nettype wire

// File: tb/tb_easyaxi_ost_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_easyaxi_ost_sched
// Description : Self-checking bench for easyaxi_ost_sched. A slot-table model
//               predicts every registered output each cycle; directed
//               scenarios add literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_easyaxi_ost_sched;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int LW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] alloc_id;
    logic [LW-1:0] alloc_len;
    logic [PW-1:0] alloc_ptr;
    logic          done_valid;
    logic [PW-1:0] done_ptr;
    logic [N-1:0]  order_bits;
    logic          resp_valid;
    logic          resp_ready;
    logic [PW-1:0] resp_ptr;
    logic [IW-1:0] resp_id;
    logic          resp_last;

    easyaxi_ost_sched #(
        .OST_DEPTH (N),
        .ID_WIDTH  (IW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_id    (alloc_id),
        .alloc_len   (alloc_len),
        .alloc_ptr   (alloc_ptr),
        .done_valid  (done_valid),
        .done_ptr    (done_ptr),
        .order_bits  (order_bits),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_ptr    (resp_ptr),
        .resp_id     (resp_id),
        .resp_last   (resp_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int order_q[$];

    // Model: slot table (0 free, 1 busy, 2 ready) plus the burst in flight
    int m_st  [N];
    int m_id  [N];
    int m_len [N];
    bit m_iss;
    int m_sel;
    int m_cnt;
    int m_rr;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_id[i] = 0; m_len[i] = 0;
        end
        m_iss = 0; m_sel = 0; m_cnt = 0; m_rr = N - 1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic void compare();
        int ff;
        ff = first_free();
        chk("alloc_ready", int'(alloc_ready), (ff >= 0) ? 1 : 0);
        if (ff >= 0) chk("alloc_ptr", int'(alloc_ptr), ff);
        chk("resp_valid", int'(resp_valid), int'(m_iss));
        if (m_iss) begin
            chk("resp_ptr", int'(resp_ptr), m_sel);
            chk("resp_id", int'(resp_id), m_id[m_sel]);
            chk("resp_last", int'(resp_last), (m_cnt == m_len[m_sel]) ? 1 : 0);
        end else begin
            chk("resp_last_idle", int'(resp_last), 0);
        end
    endfunction

    // Advance the model across one rising edge using the current inputs
    function automatic void model_step();
        int a_slot, d_slot, f_slot, j;
        if (rst) begin
            model_reset();
            return;
        end
        a_slot = -1; d_slot = -1; f_slot = -1;
        if (alloc_valid) a_slot = first_free();
        if (done_valid && m_st[done_ptr] == 1) d_slot = int'(done_ptr);
        if (m_iss) begin
            if (resp_ready) begin
                if (m_cnt == m_len[m_sel]) begin
                    f_slot = m_sel;
                    m_iss  = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (m_rr + k) % N;
                if (m_st[j] == 2 && order_bits[j]) begin
                    m_sel = j; m_rr = j; m_cnt = 0; m_iss = 1;
                    break;
                end
            end
        end
        if (a_slot >= 0) begin
            m_st[a_slot] = 1; m_id[a_slot] = int'(alloc_id); m_len[a_slot] = int'(alloc_len);
        end
        if (d_slot >= 0) m_st[d_slot] = 2;
        if (f_slot >= 0) m_st[f_slot] = 0;
    endfunction

    task automatic cycle();
        compare();
        if (resp_valid && resp_ready && resp_last) order_q.push_back(int'(resp_ptr));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int id, input int len);
        alloc_valid = 1'b1;
        alloc_id    = IW'(id);
        alloc_len   = LW'(len);
        cycle();
        alloc_valid = 1'b0;
    endtask

    task automatic do_done(input int p);
        done_valid = 1'b1;
        done_ptr   = PW'(p);
        cycle();
        done_valid = 1'b0;
    endtask

    task automatic wait_last(input string nm, input int limit);
        bit got;
        got = 0;
        for (int i = 0; i < limit; i++) begin
            if (resp_valid && resp_ready && resp_last) got = 1;
            cycle();
            if (got) break;
        end
        chk(nm, int'(got), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0; done_valid = 1'b0; order_bits = '0; resp_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats, last_at, vcnt;
        rst = 1'b1; alloc_valid = 1'b0; alloc_id = '0; alloc_len = '0;
        done_valid = 1'b0; done_ptr = '0; order_bits = '0; resp_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        cycle();

        // Reset state
        chk("rst_alloc_ready", int'(alloc_ready), 1);
        chk("rst_alloc_ptr", int'(alloc_ptr), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_ptr", int'(resp_ptr), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_last", int'(resp_last), 0);
        rst = 1'b0;

        // Three allocations land in slots 0,1,2
        for (int i = 0; i < 3; i++) begin
            chk("s3_alloc_ready", int'(alloc_ready), 1);
            chk("s3_alloc_ptr", int'(alloc_ptr), i);
            do_alloc(i, i % 3);
        end
        chk("s3_alloc_ptr_after", int'(alloc_ptr), 3);

        // Fill the table, then free slot 5 through a full issue
        for (int i = 3; i < N; i++) do_alloc(i, i % 3);
        chk("full_alloc_ready", int'(alloc_ready), 0);
        order_bits = 16'h0020;
        resp_ready = 1'b1;
        do_done(5);
        wait_last("slot5_drained", 20);
        chk("refill_alloc_ready", int'(alloc_ready), 1);
        chk("refill_alloc_ptr", int'(alloc_ptr), 5);
        do_reset();

        // len=3 burst with toggling resp_ready
        do_alloc(1, 0);
        do_alloc(2, 0);
        do_alloc(10, 3);
        order_bits = 16'h0004;
        do_done(2);
        beats = 0; last_at = 0;
        for (int i = 0; i < 40; i++) begin
            resp_ready = i[0];
            if (resp_valid) begin
                chk("burst_ptr_stable", int'(resp_ptr), 2);
                chk("burst_id_stable", int'(resp_id), 10);
                if (resp_ready) begin
                    beats++;
                    chk("burst_last_pos", int'(resp_last), (beats == 4) ? 1 : 0);
                    if (resp_last) last_at = beats;
                end
            end
            cycle();
            if (last_at != 0) break;
        end
        chk("burst_beats", beats, 4);
        chk("burst_last_at", last_at, 4);
        resp_ready = 1'b1;
        cycle();
        chk("burst_no_extra", int'(resp_valid), 0);
        do_reset();

        // Round-robin order after last grant 4: 9,1,4
        for (int i = 0; i < 10; i++) do_alloc(i, 0);
        order_bits = 16'h0010;
        resp_ready = 1'b1;
        do_done(1);
        do_done(4);
        do_done(9);
        wait_last("rr_first4", 20);
        order_bits = '0;
        chk("rr_realloc_ptr", int'(alloc_ptr), 4);
        do_alloc(4, 0);
        do_done(4);
        order_bits = '1;
        order_q.delete();
        for (int i = 0; i < 30 && order_q.size() < 3; i++) cycle();
        chk("rr_count", order_q.size(), 3);
        if (order_q.size() >= 3) begin
            chk("rr_grant0", order_q[0], 9);
            chk("rr_grant1", order_q[1], 1);
            chk("rr_grant2", order_q[2], 4);
        end
        do_reset();

        // Ready slot blocked by order_bits until released
        for (int i = 0; i < 4; i++) do_alloc(i, 1);
        order_bits = 16'hFFF7;
        resp_ready = 1'b1;
        do_done(3);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) vcnt++;
            cycle();
        end
        chk("blocked_valid_cycles", vcnt, 0);
        order_q.delete();
        order_bits = '1;
        wait_last("unblocked_drain", 10);
        if (order_q.size() > 0) chk("unblocked_ptr", order_q[0], 3);
        do_reset();

        // Reset during beat 2 of a len=7 burst
        do_alloc(5, 7);
        order_bits = 16'h0001;
        resp_ready = 1'b1;
        do_done(0);
        for (int i = 0; i < 10 && !resp_valid; i++) cycle();
        chk("abort_beat1_valid", int'(resp_valid), 1);
        cycle();
        chk("abort_beat2_valid", int'(resp_valid), 1);
        rst = 1'b1;
        cycle();
        chk("abort_resp_valid", int'(resp_valid), 0);
        chk("abort_resp_last", int'(resp_last), 0);
        chk("abort_alloc_ready", int'(alloc_ready), 1);
        chk("abort_alloc_ptr", int'(alloc_ptr), 0);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("abort_stays_idle", int'(resp_valid), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(299) == 0);
            alloc_valid = $urandom_range(1);
            alloc_id    = IW'($urandom);
            alloc_len   = LW'($urandom_range(3));
            done_valid  = ($urandom_range(3) != 0);
            done_ptr    = PW'($urandom);
            order_bits  = N'($urandom | $urandom);
            resp_ready  = ($urandom_range(3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
